// File: rtl/mdu_hilo.sv
// Multi-cycle MIPS multiply/divide unit holding the HI/LO register pair.
// Optional build macro MDU_DIV0_RESULT_EN: divide-by-zero commits hi=a, lo=all-ones.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [0:0]  state;
  logic [3:0]  counter;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_commit;

  // Handshake: start is accepted on a rising edge only while busy is low;
  // any strobe seen while busy is high is dropped (the hazard unit stalls).
  logic accept;
  assign busy   = (state == RUN);
  assign accept = start && (state == IDLE);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide via magnitudes; the zero divisor is replaced to keep X out of the datapath.
  logic        div_zero;
  logic [31:0] div_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign div_zero = (b == 32'd0);
  assign div_b    = div_zero ? 32'd1 : b;
  assign abs_a    = a[31] ? (~a + 32'd1) : a;
  assign abs_b    = div_b[31] ? (~div_b + 32'd1) : div_b;
  assign uq_s     = abs_a / abs_b;
  assign ur_s     = abs_a % abs_b;
  assign q_s      = (a[31] ^ div_b[31]) ? (~uq_s + 32'd1) : uq_s;
  assign r_s      = a[31] ? (~ur_s + 32'd1) : ur_s;
  assign q_u      = a / div_b;
  assign r_u      = a % div_b;

  logic        is_long;
  logic [3:0]  nxt_count;
  logic [31:0] nxt_hi;
  logic [31:0] nxt_lo;
  logic        nxt_commit;

  always_comb begin
    is_long    = 1'b0;
    nxt_count  = 4'd0;
    nxt_hi     = 32'd0;
    nxt_lo     = 32'd0;
    nxt_commit = 1'b0;
    case (mdu_op)
      OP_MULT: begin
        is_long    = 1'b1;
        nxt_count  = MULT_LOAD;
        nxt_hi     = prod_s[63:32];
        nxt_lo     = prod_s[31:0];
        nxt_commit = 1'b1;
      end
      OP_MULTU: begin
        is_long    = 1'b1;
        nxt_count  = MULT_LOAD;
        nxt_hi     = prod_u[63:32];
        nxt_lo     = prod_u[31:0];
        nxt_commit = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        is_long   = 1'b1;
        nxt_count = DIV_LOAD;
        if (div_zero) begin
`ifdef MDU_DIV0_RESULT_EN
          nxt_hi     = a;
          nxt_lo     = 32'hFFFF_FFFF;
          nxt_commit = 1'b1;
`else
          nxt_commit = 1'b0;
`endif
        end else begin
          nxt_hi     = (mdu_op == OP_DIV) ? r_s : r_u;
          nxt_lo     = (mdu_op == OP_DIV) ? q_s : q_u;
          nxt_commit = 1'b1;
        end
      end
      default: begin
        is_long = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      counter     <= 4'd0;
      pend_hi     <= 32'd0;
      pend_lo     <= 32'd0;
      pend_commit <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_long) begin
            state       <= RUN;
            counter     <= nxt_count;
            pend_hi     <= nxt_hi;
            pend_lo     <= nxt_lo;
            pend_commit <= nxt_commit;
          end else if (accept && mdu_op == OP_MTHI) begin
            hi <= a;
          end else if (accept && mdu_op == OP_MTLO) begin
            lo <= a;
          end
        end
        RUN: begin
          if (counter <= 4'd1) begin
            state   <= IDLE;
            counter <= 4'd0;
            if (pend_commit) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            counter <= counter - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: hand-computed HI/LO results and busy timing.
module tb_mdu_hilo;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int n;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one start strobe for exactly one rising edge; returns 1ns after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    a      = va;
    b      = vb;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = 3'd0;
  endtask

  // Counts sampled busy cycles until busy falls, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    mdu_op = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // MULT -2 * 3
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_hold_hi", hi, 32'd0);
    wait_idle(n);
    check("mult_busy_len", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU same operands
    issue(3'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("multu_busy_len", n, 32'd5);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    // DIV -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_busy_len", n, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 7 / 2
    issue(3'd4, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // DIV overflow case
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // MTHI / MTLO take effect on the issuing edge
    issue(3'd5, 32'h1234_5678, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'h9ABC_DEF0, 32'd0);
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", hi, 32'h1234_5678);

    // No-op codes 0 and 7 leave everything alone
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    check("op7_hi", hi, 32'h1234_5678);
    check("op7_lo", lo, 32'h9ABC_DEF0);
    check("op7_busy", {31'd0, busy}, 32'd0);
    issue(3'd0, 32'hDEAD_BEEF, 32'd1);
    check("op0_lo", lo, 32'h9ABC_DEF0);

    // MTLO while DIV busy is ignored; DIVU 100/7 -> q=14 r=2
    issue(3'd4, 32'd100, 32'd7);
    issue(3'd6, 32'hCAFE_F00D, 32'd0);
    check("mtlo_busy_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_busy_hi", hi, 32'h1234_5678);
    wait_idle(n);
    check("mtlo_busy_rest", n, 32'd9);
    check("busydiv_lo", lo, 32'd14);
    check("busydiv_hi", hi, 32'd2);

    // Start on the last busy cycle is ignored: MULT 3*4, MTHI on commit edge
    issue(3'd1, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    check("lastbusy_busy", {31'd0, busy}, 32'd1);
    issue(3'd5, 32'hAAAA_5555, 32'd0);
    check("lastbusy_done", {31'd0, busy}, 32'd0);
    check("lastbusy_hi", hi, 32'd0);
    check("lastbusy_lo", lo, 32'd12);

    // Async reset in the middle of a MULT
    issue(3'd5, 32'h0BAD_0BAD, 32'd0);
    issue(3'd1, 32'd1000, 32'd1000);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("arst_nolate_busy", {31'd0, busy}, 32'd0);
    check("arst_nolate_hi", hi, 32'd0);
    check("arst_nolate_lo", lo, 32'd0);

    // Divide by zero
    issue(3'd5, 32'h1111_2222, 32'd0);
    issue(3'd6, 32'h3333_4444, 32'd0);
    issue(3'd3, 32'h0000_0055, 32'd0);
    wait_idle(n);
    check("div0_busy_len", n, 32'd10);
`ifdef MDU_DIV0_RESULT_EN
    check("div0_hi", hi, 32'h0000_0055);
    check("div0_lo", lo, 32'hFFFF_FFFF);
`else
    check("div0_hi", hi, 32'h1111_2222);
    check("div0_lo", lo, 32'h3333_4444);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
